// File: rtl/mon_exp.sv
// mon_exp: Montgomery modular exponentiator, ans = M^e mod n via radix-2 Montgomery products.
// Define MON_EXP_WRITEBACK_EN to write x_bar back to bram addr0/1 after every product.
module mon_exp #(
    parameter int BIT_LEN = 1024,
    parameter int ABITS   = 8,
    parameter int DBITS   = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIT_LEN-1:0] e,
    input  logic [9:0]         e_idx,
    input  logic [BIT_LEN-1:0] n,
    input  logic [9:0]         mp_count,
    output logic [ABITS-1:0]   rd_addr,
    input  logic [DBITS-1:0]   rd_data,
    output logic [ABITS-1:0]   wr_addr,
    output logic [DBITS-1:0]   wr_data,
    output logic               wr_en,
    output logic               stop,
    output logic [BIT_LEN:0]   ans
);
    typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, WB, CONV, DONE} state_t;
    state_t state, nxt;
    logic [BIT_LEN-1:0] e_r, n_r, x, m, b_op, res;
    logic [9:0] idx, mpc, j;
    logic [2:0] cnt;
    logic [BIT_LEN+1:0] s, s_add, s_odd;
    logic a_bit, from_sqr, take_mul, dec;
`ifdef MON_EXP_WRITEBACK_EN
    logic last_sqr;
    assign from_sqr = (state == WB) ? last_sqr : (state == SQR);
`else
    assign from_sqr = (state == SQR);
    assign wr_en    = 1'b0;
    assign wr_addr  = '0;
    assign wr_data  = '0;
`endif
    always_comb begin
        a_bit    = (state == MUL) ? m[j] : x[j];
        b_op     = (state == CONV) ? BIT_LEN'(1) : x;
        s_add    = s + (a_bit ? {2'b0, b_op} : '0);
        s_odd    = s_add + (s_add[0] ? {2'b0, n_r} : '0);
        res      = BIT_LEN'((s >= {2'b0, n_r}) ? s - {2'b0, n_r} : s);
        take_mul = from_sqr && e_r[idx];
        nxt      = take_mul ? MUL : (idx == 10'd0) ? CONV : SQR;
        dec      = !take_mul && (idx != 10'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            e_r     <= '0;
            n_r     <= '0;
            x       <= '0;
            m       <= '0;
            s       <= '0;
            idx     <= '0;
            mpc     <= '0;
            j       <= '0;
            cnt     <= '0;
            rd_addr <= '0;
            stop    <= 1'b0;
            ans     <= '0;
`ifdef MON_EXP_WRITEBACK_EN
            last_sqr <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state   <= LOAD;
                    stop    <= 1'b0;
                    e_r     <= e;
                    n_r     <= n;
                    idx     <= e_idx;
                    mpc     <= mp_count;
                    cnt     <= '0;
                    rd_addr <= '0;
                end
                LOAD: begin
                    // read data trails the issued address by one cycle
                    cnt <= cnt + 3'd1;
                    if (cnt < 3'd3) rd_addr <= ABITS'(cnt + 3'd1);
                    case (cnt)
                        3'd1: x[DBITS-1:0]       <= rd_data;
                        3'd2: x[BIT_LEN-1:DBITS] <= rd_data;
                        3'd3: m[DBITS-1:0]       <= rd_data;
                        3'd4: m[BIT_LEN-1:DBITS] <= rd_data;
                        default: ;
                    endcase
                    if (cnt == 3'd4) begin
                        state <= SQR;
                        j     <= '0;
                        s     <= '0;
                    end
                end
                SQR, MUL, CONV: if (j != mpc) begin
                    s <= s_odd >> 1;
                    j <= j + 10'd1;
                end else begin
                    j <= '0;
                    s <= '0;
                    if (state == CONV) begin
                        ans   <= {1'b0, res};
                        stop  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x <= res;
`ifdef MON_EXP_WRITEBACK_EN
                        state    <= WB;
                        last_sqr <= (state == SQR);
                        cnt      <= '0;
                        wr_en    <= 1'b1;
                        wr_addr  <= '0;
                        wr_data  <= res[DBITS-1:0];
`else
                        state <= nxt;
                        if (dec) idx <= idx - 10'd1;
`endif
                    end
                end
`ifdef MON_EXP_WRITEBACK_EN
                WB: if (cnt == 3'd0) begin
                    cnt     <= 3'd1;
                    wr_addr <= ABITS'(1);
                    wr_data <= x[BIT_LEN-1:DBITS];
                end else begin
                    wr_en <= 1'b0;
                    state <= nxt;
                    if (dec) idx <= idx - 10'd1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mon_exp.sv
// tb_mon_exp: directed bench for mon_exp with a behavioural dual-write bram.
module tb_mon_exp;
    localparam int BL = 1024;
    localparam int AB = 8;
    localparam int DB = 512;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [BL-1:0] e = '0, n = '0;
    logic [9:0] e_idx = '0, mp_count = '0;
    logic [AB-1:0] rd_addr, wr_addr;
    logic [DB-1:0] rd_data = '0, wr_data;
    logic wr_en, stop;
    logic [BL:0] ans;

    logic [DB-1:0] mem [256];
    logic h_we = 1'b0;
    logic [AB-1:0] h_addr = '0;
    logic [DB-1:0] h_data = '0;
    logic wr_seen = 1'b0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mon_exp #(.BIT_LEN(BL), .ABITS(AB), .DBITS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .e(e), .e_idx(e_idx), .n(n),
        .mp_count(mp_count), .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .stop(stop), .ans(ans)
    );

    // host port first so the DUT port wins on an address clash
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (h_we) mem[h_addr] <= h_data;
        if (wr_en) mem[wr_addr] <= wr_data;
        if (wr_en) wr_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [BL:0] got, input logic [BL:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload();
        logic [DB-1:0] words [4];
        words[0] = DB'(435);
        words[1] = '0;
        words[2] = DB'(571);
        words[3] = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            h_we = 1'b1;
            h_addr = AB'(k);
            h_data = words[k];
        end
        @(negedge clk);
        h_we = 1'b0;
    endtask

    task automatic kick(input logic [BL-1:0] ee, input logic [9:0] ix, input logic [9:0] mc);
        e = ee;
        e_idx = ix;
        mp_count = mc;
        n = BL'(589);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_stop(input string tag);
        for (int k = 0; k < 4000 && !stop; k++) @(negedge clk);
        chk({tag, "_stop"}, (BL+1)'(stop), (BL+1)'(1));
    endtask

    task automatic run(input string tag, input logic [BL-1:0] ee, input logic [9:0] ix,
                       input logic [9:0] mc, input logic [BL:0] exp);
        preload();
        kick(ee, ix, mc);
        wait_stop(tag);
        chk({tag, "_ans"}, ans, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_stop", (BL+1)'(stop), '0);
        chk("rst_ans", ans, '0);
        chk("rst_wr_en", (BL+1)'(wr_en), '0);
        chk("rst_rd_addr", (BL+1)'(rd_addr), '0);
        rst_n = 1'b1;
        @(negedge clk);

        run("t1", BL'(300), 10'd8, 10'd10, (BL+1)'(311));
`ifdef MON_EXP_WRITEBACK_EN
        chk("t3_wb_lo", (BL+1)'(mem[0]), (BL+1)'(404));
        chk("t3_wb_hi", (BL+1)'(mem[1]), '0);
`endif
        run("t2_e1", BL'(1), 10'd0, 10'd10, (BL+1)'(199));
        run("t2_e0", BL'(0), 10'd0, 10'd10, (BL+1)'(1));
        run("mp0", BL'(300), 10'd8, 10'd0, '0);
        run("t1b", BL'(300), 10'd8, 10'd10, (BL+1)'(311));

        preload();
        kick(BL'(300), 10'd8, 10'd10);
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_stop", (BL+1)'(stop), '0);
        chk("t4_ans", ans, '0);
        chk("t4_wr_en", (BL+1)'(wr_en), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("t4_rerun", BL'(300), 10'd8, 10'd10, (BL+1)'(311));

        preload();
        kick(BL'(300), 10'd8, 10'd10);
        repeat (30) @(negedge clk);
        kick(BL'(1), 10'd0, 10'd10);
        wait_stop("t5_busy");
        chk("t5_busy_ans", ans, (BL+1)'(311));

        preload();
        chk("t5_done_held", (BL+1)'(stop), (BL+1)'(1));
        kick(BL'(300), 10'd8, 10'd10);
        chk("t5_done_drop", (BL+1)'(stop), '0);
        wait_stop("t5_rerun");
        chk("t5_rerun_ans", ans, (BL+1)'(311));

`ifndef MON_EXP_WRITEBACK_EN
        chk("t3_no_wr", (BL+1)'(wr_seen), '0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
